data_mem_if: RTL and testbench
==============================

Name: data_mem_if

Overview:
Data-memory interface stage directly downstream of memory_control. It accepts one load/store request at a time: add_bus, data_bus and RW, with RW=1 for read/LDR and RW=0 for write/STR. It runs the access against an internal word-addressed data RAM with a fixed number of wait states, then returns one response pulse carrying the read data or an error flag. The req_ready/busy outputs let the core stall while an access is in flight.

Parameters:
ADDR_W, 32, width of add_bus
DATA_W, 32, width of data_bus and rd_data
DEPTH, 256, number of DATA_W-bit words in the internal RAM
WAIT_CYCLES, 2, extra wait states per access (0..15)

Ports:
clk  input  1  system clock; all logic on rising edge
rst_n  input  1  synchronous active-low reset
req_valid  input  1  request present (driven when memory_control asserts LDR or STR)
req_ready  output  1  block can accept a request this cycle
RW  input  1  1 = read (LDR), 0 = write (STR)
add_bus  input  ADDR_W  byte address of the access
data_bus  input  DATA_W  store data; used only when RW=0
rsp_valid  output  1  one-cycle response strobe
rsp_err  output  1  qualifies rsp_valid; access rejected
rd_data  output  DATA_W  load result
busy  output  1  access in flight (state != IDLE)

Behaviour:
- Interface: one clock (clk); reset rst_n is synchronous and active-low. It is sampled only on the rising edge of clk. While rst_n=0, every register takes its reset value at each edge.
- Reset values:
  - state = IDLE
  - rsp_valid = 0, rsp_err = 0, rd_data = 0
  - wait counter = 0
  - request latches = 0
- RAM contents are not reset and are undefined until written.
- req_ready = (state == IDLE), combinational. busy = !req_ready.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - A handshake occurs when req_valid && req_ready at a clock edge.
  - On handshake, latch add_bus, data_bus and RW.
  - Address check: misaligned if add_bus[1:0] != 0; out of range if add_bus[ADDR_W-1:2] >= DEPTH.
  - Any check failure: go to RESP with err pending. No RAM write occurs.
  - Otherwise: go to WAIT with cnt = WAIT_CYCLES.
- WAIT:
  - If cnt != 0: cnt decrements by 1.
  - If cnt == 0, the access happens at this edge and the FSM goes to RESP:
    - Write: RAM[idx] <= latched data.
    - Read: rd_data <= RAM[idx].
- RESP:
  - rsp_valid = 1 for exactly one cycle.
  - rsp_err = 1 only for a rejected request.
  - Next edge returns to IDLE unconditionally.
  - req_ready is 0 during RESP, so a back-to-back request is accepted in the cycle after RESP at the earliest.
- Latency, handshake in cycle T:
  - Valid access: rsp_valid in cycle T + WAIT_CYCLES + 2.
  - Rejected request: rsp_valid in cycle T + 1.
- rd_data:
  - Updated only on a successful read.
  - Holds its prior value through writes.
  - Forced to 0 on a rejected request.
  - Stable from RESP until the next update.
- req_valid while req_ready=0 is ignored. Upstream holds the request until the handshake. Inputs other than rst_n are don't-care outside the handshake edge.
- rsp_valid and rsp_err are 0 in every state except RESP.
- Reset mid-operation: rst_n=0 in WAIT or RESP returns to IDLE at that edge. A write whose access edge coincides with rst_n=0 is not performed. No response is emitted for an aborted request.
- Index arithmetic: idx = add_bus[ADDR_W-1:2], compared unsigned against DEPTH. Address bits above clog2(DEPTH)+2 must still be zero for a valid access; no wrap-around aliasing.

Test Plan:
- Reset, then idle for 3 cycles → req_ready=1, busy=0, rsp_valid=0, rd_data=0.
- Store then load, WAIT_CYCLES=2:
  - Write 0xDEADBEEF to add_bus=0x10, handshake cycle T → rsp_valid=1, rsp_err=0 exactly at T+4, req_ready=0 during T+1..T+4.
  - Then read 0x10 → rd_data=0xDEADBEEF at its RESP cycle.
- Rejected requests:
  - Read at add_bus=0x13 (misaligned) → rsp_valid=1, rsp_err=1 at T+1, rd_data=0.
  - Write to 0x400 (idx 256 ≥ DEPTH) → rsp_err=1, and a later read of word 0 is unchanged.
- Back-to-back requests with req_valid held high for 3 requests → handshakes spaced WAIT_CYCLES+3 = 5 cycles apart. No request is lost or duplicated; responses arrive in order.
- Reset mid-access: write 0x12345678 to 0x20 over old value 0xA5A5A5A5, assert rst_n=0 in the first WAIT cycle → no rsp_valid, state IDLE. A subsequent read of 0x20 returns 0xA5A5A5A5.
- WAIT_CYCLES=0 build → a valid read's rsp_valid at T+2. Address 0x3FC (last word) is accepted; 0x400 is rejected.

Source files
------------

// File: rtl/data_mem_if.sv
// data_mem_if: single-outstanding load/store stage in front of a word-addressed
// data RAM. Every access takes a fixed number of wait states. Bad addresses are
// rejected right away with an error response.
module data_mem_if #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              RW,
    input  logic [ADDR_W-1:0] add_bus,
    input  logic [DATA_W-1:0] data_bus,
    output logic              rsp_valid,
    output logic              rsp_err,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-3:0] DEPTH_WORDS = (ADDR_W-2)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t state;
    state_t next_state;

    logic [3:0]        cnt;
    logic [IDX_W-1:0]  lat_idx;
    logic [DATA_W-1:0] lat_data;
    logic              lat_rw;
    logic              lat_err;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              handshake;
    logic              addr_bad;
    logic              access;
    logic [ADDR_W-3:0] word_addr;

    // The full upper address is compared, so out-of-range addresses never alias onto a valid word
    assign word_addr = add_bus[ADDR_W-1:2];
    assign addr_bad  = (add_bus[1:0] != 2'b00) || (word_addr >= DEPTH_WORDS);

    assign req_ready = (state == IDLE);
    assign busy      = ~req_ready;
    assign handshake = req_valid && req_ready;
    assign access    = (state == WAIT) && (cnt == 4'd0);
    assign rsp_valid = (state == RESP);
    assign rsp_err   = (state == RESP) && lat_err;

    // State register with synchronous reset back to IDLE
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: rejected requests skip WAIT and respond on the next cycle
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (handshake) begin
                    next_state = addr_bad ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    next_state = RESP;
                end
            end
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Capture the request at the handshake, then count down the wait states
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt      <= 4'd0;
            lat_idx  <= '0;
            lat_data <= '0;
            lat_rw   <= 1'b0;
            lat_err  <= 1'b0;
        end else if (handshake) begin
            cnt      <= 4'(WAIT_CYCLES);
            lat_idx  <= add_bus[IDX_W+1:2];
            lat_data <= data_bus;
            lat_rw   <= RW;
            lat_err  <= addr_bad;
        end else if ((state == WAIT) && (cnt != 4'd0)) begin
            cnt <= cnt - 4'd1;
        end
    end

    // RAM store: an access edge that coincides with reset must not write
    always_ff @(posedge clk) begin
        if (rst_n && access && !lat_rw) begin
            mem[lat_idx] <= lat_data;
        end
    end

    // Load result: cleared on a reject, loaded on a good read, otherwise held
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (handshake && addr_bad) begin
            rd_data <= '0;
        end else if (access && lat_rw) begin
            rd_data <= mem[lat_idx];
        end
    end

endmodule

// File: tb/tb_data_mem_if.sv
// tb_data_mem_if: randomized bench for data_mem_if. A transaction-level model
// predicts every output on every cycle. Directed scenarios pin literal values.
module tb_data_mem_if;

    localparam int ADDR_W      = 32;
    localparam int DATA_W      = 32;
    localparam int DEPTH       = 256;
    localparam int WAIT_CYCLES = 2;
    localparam int RSP_LAT     = WAIT_CYCLES + 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_valid = 1'b0;
    logic              RW = 1'b0;
    logic [ADDR_W-1:0] add_bus = '0;
    logic [DATA_W-1:0] data_bus = '0;
    logic              req_ready;
    logic              rsp_valid;
    logic              rsp_err;
    logic [DATA_W-1:0] rd_data;
    logic              busy;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    // Reference model: one outstanding request, with an absolute response cycle
    bit          m_busy = 1'b0;
    bit          m_ready_prev;
    int          m_rsp_at = -1;
    bit          m_err;
    bit          m_rw;
    int          m_idx;
    logic [31:0] m_data;
    logic [31:0] m_rd = '0;
    logic [31:0] m_mem [DEPTH];

    int pool_idx [8] = '{0, 1, 4, 5, 8, 63, 128, 255};

    always #5 clk = ~clk;

    data_mem_if #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .DEPTH(DEPTH),
        .WAIT_CYCLES(WAIT_CYCLES)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .RW(RW),
        .add_bus(add_bus),
        .data_bus(data_bus),
        .rsp_valid(rsp_valid),
        .rsp_err(rsp_err),
        .rd_data(rd_data),
        .busy(busy)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model update at each rising edge; cyc becomes the index of the cycle now starting
    initial forever begin
        @(posedge clk);
        cyc++;
        if (!rst_n) begin
            m_busy = 1'b0;
            m_rd   = '0;
        end else begin
            m_ready_prev = !m_busy;
            if (m_busy && (cyc - 1) == m_rsp_at) begin
                m_busy = 1'b0;
            end
            if (m_ready_prev && req_valid) begin
                m_err    = ((add_bus % 4) != 0) || ((add_bus / 4) >= DEPTH);
                m_rw     = RW;
                m_idx    = int'(add_bus / 4);
                m_data   = data_bus;
                m_busy   = 1'b1;
                m_rsp_at = m_err ? cyc : (cyc - 1 + RSP_LAT);
                if (m_err) begin
                    m_rd = '0;
                end
            end else if (m_busy && cyc == m_rsp_at && !m_err) begin
                if (m_rw) begin
                    m_rd = m_mem[m_idx];
                end else begin
                    m_mem[m_idx] = m_data;
                end
            end
        end
    end

    // Compare every output against the model on each falling edge
    initial forever begin
        @(negedge clk);
        if (cyc > 0) begin
            checkOutput("req_ready", 32'(req_ready), 32'(!m_busy));
            checkOutput("busy", 32'(busy), 32'(m_busy));
            checkOutput("rsp_valid", 32'(rsp_valid), 32'(m_busy && cyc == m_rsp_at));
            checkOutput("rsp_err", 32'(rsp_err), 32'(m_busy && cyc == m_rsp_at && m_err));
            checkOutput("rd_data", rd_data, m_rd);
        end
    end

    // One request: hold it until the handshake, then wait for its response
    task automatic applyStimulus(input logic rw_i, input logic [31:0] addr_i, input logic [31:0] data_i,
                                 output int hs_cyc, output int rsp_cyc,
                                 output logic err_o, output logic [31:0] rd_o);
        int guard;
        hs_cyc  = -1;
        rsp_cyc = -1;
        err_o   = 1'b0;
        rd_o    = '0;
        @(negedge clk);
        req_valid = 1'b1;
        RW        = rw_i;
        add_bus   = addr_i;
        data_bus  = data_i;
        guard = 0;
        while (!req_ready && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("handshake_timeout", 32'(req_ready), 32'd1);
        if (!req_ready) begin
            req_valid = 1'b0;
            return;
        end
        hs_cyc = cyc;
        @(negedge clk);
        req_valid = 1'b0;
        RW        = 1'($urandom_range(0, 1));
        add_bus   = $urandom;
        data_bus  = $urandom;
        guard = 0;
        while (!rsp_valid && guard < 40) begin
            req_valid = 1'($urandom_range(0, 1));
            @(negedge clk);
            guard++;
        end
        req_valid = 1'b0;
        checkOutput("response_timeout", 32'(rsp_valid), 32'd1);
        if (rsp_valid) begin
            rsp_cyc = cyc;
            err_o   = rsp_err;
            rd_o    = rd_data;
        end
    endtask

    // Request that is aborted by a one-cycle reset some cycles after its handshake
    task automatic abortAccess(input logic rw_i, input logic [31:0] addr_i, input logic [31:0] data_i,
                               input int delay);
        int guard;
        @(negedge clk);
        req_valid = 1'b1;
        RW        = rw_i;
        add_bus   = addr_i;
        data_bus  = data_i;
        guard = 0;
        while (!req_ready && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("abort_handshake_timeout", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (delay) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Hard stop in case the whole run stalls
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios followed by randomized traffic
    initial begin
        int          hs;
        int          rs;
        logic        e;
        logic [31:0] d;
        logic [31:0] pre_val [8];
        logic [31:0] b2b_addr [3];
        logic [31:0] got [$];
        int          hsq [3];
        int          k;
        bit          adv;
        int          guard;
        int          nrsp;
        logic [31:0] a;
        int          r;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset_req_ready", 32'(req_ready), 32'd1);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("reset_rd_data", rd_data, 32'd0);

        pre_val = '{32'h0BADF00D, 32'h11111111, $urandom, 32'h55555555,
                    32'hA5A5A5A5, 32'h63636363, $urandom, $urandom};
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 32'(pool_idx[i] * 4), pre_val[i], hs, rs, e, d);
        end

        applyStimulus(1'b0, 32'h10, 32'hDEADBEEF, hs, rs, e, d);
        checkOutput("store_latency", 32'(rs - hs), 32'd4);
        checkOutput("store_err", 32'(e), 32'd0);
        applyStimulus(1'b1, 32'h10, 32'h0, hs, rs, e, d);
        checkOutput("load_latency", 32'(rs - hs), 32'd4);
        checkOutput("load_data", d, 32'hDEADBEEF);

        applyStimulus(1'b1, 32'h13, 32'h0, hs, rs, e, d);
        checkOutput("misaligned_latency", 32'(rs - hs), 32'd1);
        checkOutput("misaligned_err", 32'(e), 32'd1);
        checkOutput("misaligned_rd_data", d, 32'd0);

        applyStimulus(1'b0, 32'h400, 32'hFFFF0000, hs, rs, e, d);
        checkOutput("range_err", 32'(e), 32'd1);
        applyStimulus(1'b1, 32'h0, 32'h0, hs, rs, e, d);
        checkOutput("word0_unchanged", d, 32'h0BADF00D);

        b2b_addr = '{32'h04, 32'h14, 32'hFC};
        k   = 0;
        adv = 1'b0;
        got.delete();
        @(negedge clk);
        req_valid = 1'b1;
        RW        = 1'b1;
        add_bus   = b2b_addr[0];
        data_bus  = $urandom;
        guard = 0;
        while (got.size() < 3 && guard < 60) begin
            if (adv) begin
                adv = 1'b0;
                if (k < 3) begin
                    add_bus = b2b_addr[k];
                end else begin
                    req_valid = 1'b0;
                end
            end
            if (rsp_valid) begin
                got.push_back(rd_data);
            end
            if (req_valid && req_ready && k < 3) begin
                hsq[k] = cyc;
                k++;
                adv = 1'b1;
            end
            @(negedge clk);
            guard++;
        end
        req_valid = 1'b0;
        checkOutput("b2b_handshakes", 32'(k), 32'd3);
        checkOutput("b2b_responses", 32'(got.size()), 32'd3);
        if (k == 3) begin
            checkOutput("b2b_spacing_0", 32'(hsq[1] - hsq[0]), 32'd5);
            checkOutput("b2b_spacing_1", 32'(hsq[2] - hsq[1]), 32'd5);
        end
        if (got.size() == 3) begin
            checkOutput("b2b_data_0", got[0], 32'h11111111);
            checkOutput("b2b_data_1", got[1], 32'h55555555);
            checkOutput("b2b_data_2", got[2], 32'h63636363);
        end

        abortAccess(1'b0, 32'h20, 32'h12345678, 0);
        nrsp = 0;
        repeat (8) begin
            if (rsp_valid) begin
                nrsp++;
            end
            @(negedge clk);
        end
        checkOutput("abort_no_response", 32'(nrsp), 32'd0);
        checkOutput("abort_idle", 32'(req_ready), 32'd1);
        applyStimulus(1'b1, 32'h20, 32'h0, hs, rs, e, d);
        checkOutput("abort_old_value", d, 32'hA5A5A5A5);

        applyStimulus(1'b0, 32'h3FC, 32'hCAFEF00D, hs, rs, e, d);
        checkOutput("last_word_err", 32'(e), 32'd0);
        applyStimulus(1'b1, 32'h3FC, 32'h0, hs, rs, e, d);
        checkOutput("last_word_data", d, 32'hCAFEF00D);
        applyStimulus(1'b1, 32'h400, 32'h0, hs, rs, e, d);
        checkOutput("past_end_err", 32'(e), 32'd1);

        for (int i = 0; i < 200; i++) begin
            r = int'($urandom_range(0, 7));
            if (r < 6) begin
                a = 32'(pool_idx[$urandom_range(0, 7)] * 4);
            end else begin
                case ($urandom_range(0, 3))
                    0:       a = 32'(pool_idx[$urandom_range(0, 7)] * 4 + int'($urandom_range(1, 3)));
                    1:       a = 32'h400 + 32'(4 * $urandom_range(0, 100));
                    2:       a = ($urandom | 32'h8000_0000) & 32'hFFFF_FFFC;
                    default: a = 32'hFFFF_FFFC;
                endcase
            end
            if ($urandom_range(0, 19) == 0) begin
                abortAccess(1'($urandom_range(0, 1)), a, $urandom, int'($urandom_range(0, RSP_LAT - 1)));
            end else begin
                applyStimulus(1'($urandom_range(0, 1)), a, $urandom, hs, rs, e, d);
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
